// File: rtl/chunked_adder.sv
// Multi-cycle two's-complement adder/subtractor: adds CHUNK bits per clock,
// LSB chunk first, with a registered carry between chunks and valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | adding chunk k per cycle, carry held in a register
// DONE  | result held on s/cout/ovf with out_valid high until accepted
module chunked_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [KW-1:0]    k;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   slice;
   logic             carry_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)   state_nx = RUN;
         RUN:     if (k == K_LAST) state_nx = DONE;
         DONE:    if (out_ready)  state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   assign in_ready = (state == IDLE);

   always_comb begin
      a_chunk = a_reg[k*CHUNK +: CHUNK];
      b_chunk = b_reg[k*CHUNK +: CHUNK];
      slice   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
      // Carry into the slice MSB, recovered from its sum bit and operand bits.
      carry_msb = slice[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry     <= 1'b0;
         k         <= '0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  // Subtraction is a + ~b + ~cin, so the borrow-in is inverted too.
                  b_reg <= sub ? ~b : b;
                  carry <= cin ^ sub;
                  k     <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               s[k*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
               carry               <= slice[CHUNK];
               if (k == K_LAST) begin
                  cout      <= slice[CHUNK];
                  ovf       <= carry_msb ^ slice[CHUNK];
                  out_valid <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: a 16/4 instance plus 4/1 and 4/4 instances
// driven side by side with the same operands.
module tb_chunked_adder;

   logic        clk;
   logic        rst_n;

   logic        iv16, ir16, ov16, or16, cin16, sub16, co16, vf16, bz16;
   logic [15:0] a16, b16, s16;

   logic        iv4, or4, cin4, sub4;
   logic [3:0]  a4, b4, s4a, s4b;
   logic        ir4a, ov4a, co4a, vf4a, bz4a;
   logic        ir4b, ov4b, co4b, vf4b, bz4b;

   int total  = 0;
   int passed = 0;

   chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .cin(cin16), .sub(sub16),
      .out_valid(ov16), .out_ready(or16), .s(s16), .cout(co16), .ovf(vf16), .busy(bz16)
   );

   chunked_adder #(.WIDTH(4), .CHUNK(1)) dut4a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4a),
      .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .out_valid(ov4a), .out_ready(or4), .s(s4a), .cout(co4a), .ovf(vf4a), .busy(bz4a)
   );

   chunked_adder #(.WIDTH(4), .CHUNK(4)) dut4b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4b),
      .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .out_valid(ov4b), .out_ready(or4), .s(s4b), .cout(co4b), .ovf(vf4b), .busy(bz4b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic sb);
      a16 = av; b16 = bv; cin16 = c; sub16 = sb; iv16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv16 = 1'b0;
      a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = ~c; sub16 = ~sb;
   endtask

   task automatic wait16(input string tag, input int lat, input logic [15:0] es,
                         input logic ec, input logic ev);
      int n;
      n = 0;
      while (!ov16 && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, lat);
      check({tag, " s"}, s16, es);
      check({tag, " cout"}, co16, ec);
      check({tag, " ovf"}, vf16, ev);
   endtask

   task automatic handshake16(input string tag);
      or16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or16 = 1'b0;
      check({tag, " out_valid after ack"}, ov16, 1'b0);
      check({tag, " in_ready after ack"}, ir16, 1'b1);
   endtask

   task automatic run4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic c, input logic sb, input logic [3:0] es,
                       input logic ec, input logic ev);
      int la, lb;
      la = -1; lb = -1;
      a4 = av; b4 = bv; cin4 = c; sub4 = sb; iv4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      for (int n = 0; n < 12; n++) begin
         if (ov4a && la < 0) la = n;
         if (ov4b && lb < 0) lb = n;
         if (la >= 0 && lb >= 0) break;
         @(posedge clk);
         @(negedge clk);
      end
      check({tag, " c1 latency"}, la, 4);
      check({tag, " c4 latency"}, lb, 1);
      check({tag, " c1 s"}, s4a, es);
      check({tag, " c1 cout"}, co4a, ec);
      check({tag, " c1 ovf"}, vf4a, ev);
      check({tag, " c4 s"}, s4b, es);
      check({tag, " c4 cout"}, co4b, ec);
      check({tag, " c4 ovf"}, vf4b, ev);
      or4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or4 = 1'b0;
      check({tag, " c1 in_ready after ack"}, ir4a, 1'b1);
      check({tag, " c4 in_ready after ack"}, ir4b, 1'b1);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0;
      iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
      iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      #12;
      check("reset in_ready", ir16, 1'b1);
      check("reset out_valid", ov16, 1'b0);
      check("reset busy", bz16, 1'b0);
      check("reset s", s16, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      start16(16'h1234, 16'h4321, 1'b0, 1'b0);
      check("add_basic busy", bz16, 1'b1);
      check("add_basic in_ready", ir16, 1'b0);
      wait16("add_basic", 4, 16'h5555, 1'b0, 1'b0);
      handshake16("add_basic");

      start16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait16("carry_chain", 4, 16'h0000, 1'b1, 1'b0);
      handshake16("carry_chain");

      start16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait16("add_ovf", 4, 16'h8000, 1'b0, 1'b1);
      handshake16("add_ovf");

      start16(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait16("sub_borrow", 4, 16'hFFFE, 1'b0, 1'b0);
      handshake16("sub_borrow");

      start16(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait16("sub_ovf", 4, 16'h7FFF, 1'b1, 1'b1);
      handshake16("sub_ovf");

      start16(16'h0010, 16'h0003, 1'b1, 1'b1);
      wait16("sub_bin", 4, 16'h000C, 1'b1, 1'b0);
      handshake16("sub_bin");

      start16(16'h00FF, 16'h0000, 1'b1, 1'b0);
      wait16("add_cin", 4, 16'h0100, 1'b0, 1'b0);
      handshake16("add_cin");

      // Back-pressure with a new operation pending on the input side
      start16(16'h1111, 16'h2222, 1'b0, 1'b0);
      wait16("bp_first", 4, 16'h3333, 1'b0, 1'b0);
      a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1; or16 = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("bp hold s", s16, 16'h3333);
         check("bp hold out_valid", ov16, 1'b1);
         check("bp hold in_ready", ir16, 1'b0);
      end
      or16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or16 = 1'b0;
      check("bp ack in_ready", ir16, 1'b1);
      check("bp ack out_valid", ov16, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("bp accept in_ready", ir16, 1'b0);
      check("bp accept busy", bz16, 1'b1);
      iv16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF;
      wait16("bp_second", 4, 16'h1010, 1'b0, 1'b0);
      handshake16("bp_second");

      // Reset two cycles into RUN
      start16(16'h1234, 16'h1111, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_run in_ready", ir16, 1'b1);
      check("rst_run out_valid", ov16, 1'b0);
      check("rst_run busy", bz16, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (ov16) seen++;
      end
      check("rst_run no result", seen, 0);
      start16(16'h0F00, 16'h00F0, 1'b1, 1'b0);
      wait16("post_rst", 4, 16'h0FF1, 1'b0, 1'b0);
      handshake16("post_rst");

      run4("w4_add", 4'b1011, 4'b1001, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1);
      run4("w4_sub", 4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
